// File: rtl/ad_acq_pkg.sv
// Shared types and default timing for the AD acquisition sequencer.
package ad_acq_pkg;

  localparam int DATA_W            = 8;
  localparam int CONV_LOW_CYC_DEF  = 2;
  localparam int CONV_WAIT_CYC_DEF = 12;
  localparam int OE_CYC_DEF        = 3;
  localparam int PER_W_DEF         = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    WAIT = 3'd2,
    READ = 3'd3,
    HAND = 3'd4
  } state_e;

endpackage

// File: rtl/ad_period_tick.sv
// Sample-period counter: held at zero while run is low, otherwise counts
// down and emits a one-cycle tick on reaching zero, then reloads.
module ad_period_tick #(
  parameter int PER_W = 12
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             run,
  input  logic [PER_W-1:0] period_cyc,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q, cnt_d;

  // Next count and tick; a zero period behaves like a period of one.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = (period_cyc == '0) ? '0 : period_cyc - PER_W'(1);
    end else begin
      cnt_d = cnt_q - PER_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ad_acq_sched.sv
// AD acquisition sequencer: paces conversions, strobes the ADC, enables its
// bus driver, captures the byte and hands it to the serializer.
// Optional drop counter output ovr_cnt when AD_OVR_CNT_EN is defined.
module ad_acq_sched
  import ad_acq_pkg::*;
#(
  parameter int CONV_LOW_CYC  = CONV_LOW_CYC_DEF,
  parameter int CONV_WAIT_CYC = CONV_WAIT_CYC_DEF,
  parameter int OE_CYC        = OE_CYC_DEF,
  parameter int PER_W         = PER_W_DEF
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              run,
  input  logic [PER_W-1:0]  period_cyc,
  output logic              nGet_AD_data,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] databus,
  output logic [DATA_W-1:0] ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr
`ifdef AD_OVR_CNT_EN
  ,
  output logic [7:0]        ovr_cnt
`endif
);

  localparam logic [7:0] LOW_LAST  = 8'(CONV_LOW_CYC - 1);
  localparam logic [7:0] WAIT_LAST = 8'(CONV_WAIT_CYC - 1);
  localparam logic [7:0] OE_LAST   = 8'(OE_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        ph_q, ph_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovr_q, ovr_d;
  logic              tick;
  logic              ovr_set;

  ad_period_tick #(.PER_W(PER_W)) u_tick (
    .clk        (clk),
    .nReset     (nReset),
    .run        (run),
    .period_cyc (period_cyc),
    .tick       (tick)
  );

  // Sequencer next-state, phase counter and capture; ticks outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    data_d  = data_q;
    ovr_set = tick && (state_q != IDLE);
    case (state_q)
      IDLE: if (tick) begin state_d = CONV; ph_d = '0; end
      CONV: if (ph_q == LOW_LAST) begin state_d = WAIT; ph_d = '0; end
            else ph_d = ph_q + 8'd1;
      WAIT: if (ph_q == WAIT_LAST) begin state_d = READ; ph_d = '0; end
            else ph_d = ph_q + 8'd1;
      // Only the last enabled cycle is sampled; earlier ones let the bus settle.
      READ: if (ph_q == OE_LAST) begin state_d = HAND; ph_d = '0; data_d = databus; end
            else ph_d = ph_q + 8'd1;
      HAND: if (ser_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    ovr_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  // State, phase, captured data and overrun flag.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs decode straight from the state register so reset releases the bus at once.
  assign nGet_AD_data = (state_q != CONV);
  assign ad_oe        = (state_q == READ);
  assign ser_valid    = (state_q == HAND);
  assign busy         = (state_q != IDLE);
  assign ser_data     = data_q;
  assign overrun      = ovr_q;

`ifdef AD_OVR_CNT_EN
  logic [7:0] ocnt_q, ocnt_d;

  // Saturating count of dropped ticks; a drop takes priority over a clear.
  always_comb begin
    ocnt_d = ocnt_q;
    if (ovr_set) begin
      if (ocnt_q != 8'hFF) ocnt_d = ocnt_q + 8'd1;
    end else if (clr_ovr) begin
      ocnt_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) ocnt_q <= '0;
    else         ocnt_q <= ocnt_d;
  end

  assign ovr_cnt = ocnt_q;
`endif

endmodule

// File: tb/tb_ad_acq_sched.sv
// Bench for ad_acq_sched: ADC bus model, timing monitor and data scoreboard.
module tb_ad_acq_sched;

  localparam int LOW = 2, WT = 12, OE = 3;
  localparam int LAT = LOW + WT + OE;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        run = 1'b0;
  logic [11:0] period_cyc = '0;
  logic        nGet_AD_data, ad_oe, ser_valid, busy, overrun;
  logic [7:0]  databus = 8'hEE;
  logic [7:0]  ser_data;
  logic        ser_ready = 1'b0;
  logic        clr_ovr = 1'b0;
`ifdef AD_OVR_CNT_EN
  logic [7:0]  ovr_cnt;
`endif

  ad_acq_sched dut (
    .clk          (clk),
    .nReset       (nReset),
    .run          (run),
    .period_cyc   (period_cyc),
    .nGet_AD_data (nGet_AD_data),
    .ad_oe        (ad_oe),
    .databus      (databus),
    .ser_data     (ser_data),
    .ser_valid    (ser_valid),
    .ser_ready    (ser_ready),
    .busy         (busy),
    .overrun      (overrun),
    .clr_ovr      (clr_ovr)
`ifdef AD_OVR_CNT_EN
    ,
    .ovr_cnt      (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ADC stimulus: byte pattern across the enabled cycles, expected capture.
  logic [7:0] pat [3];
  logic [7:0] cur_exp;
  logic [7:0] exp_q [$];

  // Monitor state.
  int strobe_cnt = 0, hs_cnt = 0;
  int last_start = 0, prev_start = 0, strobe_end = 0, oe_start = 0, oe_idx = 0;
  bit prev_n = 1, prev_oe = 0, prev_v = 0, overlap = 0;

  // Timing monitor, ADC bus model and scoreboard, all on the falling edge.
  always @(negedge clk) begin
    if (!nReset) begin
      prev_n = 1; prev_oe = 0; prev_v = 0; oe_idx = 0; databus = 8'hEE;
    end else begin
      if (!nGet_AD_data && ad_oe) overlap = 1;
      if (!nGet_AD_data && prev_n) begin
        strobe_cnt++; prev_start = last_start; last_start = cyc;
        exp_q.push_back(cur_exp);
      end
      if (nGet_AD_data && !prev_n) begin
        chk("strobe_len", cyc - last_start, LOW); strobe_end = cyc;
      end
      if (ad_oe && !prev_oe) begin
        chk("conv_wait", cyc - strobe_end, WT); oe_start = cyc; oe_idx = 0;
      end
      if (!ad_oe && prev_oe) chk("oe_len", cyc - oe_start, OE);
      if (ad_oe) begin
        databus = (oe_idx < 3) ? pat[oe_idx] : 8'hEE; oe_idx++;
      end else databus = 8'hEE;
      if (ser_valid && !prev_v) chk("valid_latency", cyc - last_start, LAT);
      if (ser_valid && ser_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
        else chk("ser_data", ser_data, exp_q.pop_front());
      end
      prev_n = nGet_AD_data; prev_oe = ad_oe; prev_v = ser_valid;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond(int what, int tgt);
    case (what)
      0: return strobe_cnt >= tgt;
      1: return hs_cnt >= tgt;
      2: return !busy;
      3: return ad_oe;
      default: return ser_valid;
    endcase
  endfunction

  // Bounded wait; an expired bound is reported as a failed check.
  task automatic wait_for(int what, int tgt, int bound, string nm);
    int k = 0;
    while (!cond(what, tgt) && k < bound) begin wait_cyc(1); k++; end
    chk(nm, int'(cond(what, tgt)), 1);
  endtask

  task automatic do_reset();
    run = 0; clr_ovr = 0; nReset = 0; exp_q.delete();
    wait_cyc(2);
    nReset = 1;
    wait_cyc(1);
  endtask

  typedef struct {
    int         period;
    logic [7:0] b0, b1, b2;
    logic [7:0] exp_data;
    int         exp_interval;
    int         exp_ovr;
  } vec_t;

  vec_t vt [5];
  int rc, s0, h0;
  bit stable_bad, seen;
  int cnt_at;

  initial begin
    vt[0] = '{40, 8'h99, 8'h99, 8'h99, 8'h99, 40, 0};
    vt[1] = '{20, 8'h10, 8'h11, 8'h9A, 8'h9A, 20, 0};
    vt[2] = '{25, 8'hA5, 8'h5A, 8'h3C, 8'h3C, 25, 0};
    vt[3] = '{18, 8'h01, 8'h02, 8'hF0, 8'hF0, 36, 1};
    vt[4] = '{0,  8'h77, 8'h66, 8'h55, 8'h55, LAT + 2, 1};
    cnt_at = -1;

    // Reset values while held in reset.
    #3;
    chk("rst_nget", nGet_AD_data, 1);
    chk("rst_oe", ad_oe, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_data", ser_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
`ifdef AD_OVR_CNT_EN
    chk("rst_ovr_cnt", ovr_cnt, 0);
`endif
    wait_cyc(2);

    // Table-driven periodic acquisition.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      period_cyc = 12'(vt[i].period);
      pat[0] = vt[i].b0; pat[1] = vt[i].b1; pat[2] = vt[i].b2;
      cur_exp = vt[i].exp_data;
      ser_ready = 1;
      s0 = strobe_cnt; h0 = hs_cnt;
      run = 1; rc = cyc;
      wait_for(0, s0 + 1, 10, "first_strobe_seen");
      chk("first_strobe_cyc", last_start - rc, 1);
      wait_for(0, s0 + 2, 200, "second_strobe_seen");
      chk("interval", last_start - prev_start, vt[i].exp_interval);
      run = 0;
      wait_for(2, 0, 60, "idle");
      chk("overrun", overrun, vt[i].exp_ovr);
      chk("handoffs", hs_cnt - h0, 2);
      chk("sb_empty", exp_q.size(), 0);
    end

    // Serializer stall: data held, tick dropped, recovery after ready.
    do_reset();
    period_cyc = 12'd20; ser_ready = 0;
    pat[0] = 8'h21; pat[1] = 8'h22; pat[2] = 8'h23; cur_exp = 8'h23;
    s0 = strobe_cnt; h0 = hs_cnt;
    run = 1;
    wait_for(4, 0, 40, "stall_valid");
    stable_bad = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      wait_cyc(1);
      if (!ser_valid || ser_data != 8'h23) stable_bad = 1;
      if (overrun && !seen) begin
        seen = 1;
`ifdef AD_OVR_CNT_EN
        cnt_at = ovr_cnt;
`endif
      end
    end
    chk("stall_stable", stable_bad, 0);
    chk("stall_overrun", seen, 1);
`ifdef AD_OVR_CNT_EN
    chk("stall_ovr_cnt", cnt_at, 1);
`endif
    ser_ready = 1;
    wait_for(1, h0 + 1, 5, "stall_handoff");
    wait_for(0, s0 + 2, 30, "stall_restart");
    run = 0;
    wait_for(2, 0, 60, "stall_idle");

    // Run dropped during WAIT: sample completes, nothing follows.
    do_reset();
    period_cyc = 12'd40; ser_ready = 1;
    pat[0] = 8'h40; pat[1] = 8'h41; pat[2] = 8'h42; cur_exp = 8'h42;
    s0 = strobe_cnt; h0 = hs_cnt;
    run = 1;
    wait_for(0, s0 + 1, 10, "rf_strobe");
    wait_cyc(3);
    chk("rf_in_wait", int'(busy && nGet_AD_data && !ad_oe), 1);
    run = 0;
    wait_for(1, h0 + 1, 30, "rf_handoff");
    s0 = strobe_cnt;
    wait_cyc(100);
    chk("rf_no_more", strobe_cnt - s0, 0);
    chk("rf_idle", busy, 0);

    // Asynchronous reset during READ.
    do_reset();
    period_cyc = 12'd40; ser_ready = 1;
    pat[0] = 8'h5A; pat[1] = 8'h5B; pat[2] = 8'h5C; cur_exp = 8'h5C;
    run = 1;
    wait_for(3, 0, 40, "ar_read");
    nReset = 0; run = 0;
    #1;
    chk("ar_oe", ad_oe, 0);
    chk("ar_valid", ser_valid, 0);
    chk("ar_nget", nGet_AD_data, 1);
    chk("ar_busy", busy, 0);
    exp_q.delete();
    wait_cyc(2);
    nReset = 1;
    s0 = strobe_cnt;
    wait_cyc(10);
    chk("ar_no_strobe", strobe_cnt - s0, 0);
    run = 1; rc = cyc;
    wait_for(0, s0 + 1, 10, "ar_strobe");
    chk("ar_strobe_cyc", last_start - rc, 1);
    run = 0;
    wait_for(2, 0, 60, "ar_idle");

    // Clear coinciding with a dropped tick, then clear alone.
    do_reset();
    period_cyc = 12'd20; ser_ready = 0;
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h03; cur_exp = 8'h03;
    run = 1;
    wait_cyc(20);
    chk("clr_ovr_before", overrun, 0);
    clr_ovr = 1;
    wait_cyc(1);
    chk("clr_set_wins", overrun, 1);
    wait_cyc(1);
    clr_ovr = 0;
    chk("clr_cleared", overrun, 0);
`ifdef AD_OVR_CNT_EN
    chk("clr_ovr_cnt", ovr_cnt, 0);
`endif
    ser_ready = 1; run = 0;
    wait_for(2, 0, 10, "clr_idle");
    chk("clr_sb_empty", exp_q.size(), 0);

    chk("no_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
